// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the scoreboarded register file.
//   rf_state_t : bulk-clear sequencer state (RF_IDLE / RF_CLEAR)
//   addr_w()   : register-id width for a given register count
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // A single-register file would give $clog2 == 0, so the id width is
    // floored at one bit to keep every port a legal vector.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_sb_clear_seq
// Bulk-clear sequencer: once started it walks a pointer from register 0 to
// register DEPTH-1, one register per cycle, then returns to idle.
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-low reset
//   i_clr_req    in   start request, sampled only while idle
//   o_clr_we     out  clear-write strobe for the register array
//   o_clr_addr   out  register currently being cleared
//   o_clr_busy   out  high for exactly DEPTH cycles per clear
// -----------------------------------------------------------------------------
module regfile_sb_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_clr_req,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_ptr;

    // The pointer is parked at zero when the walk ends so it never wraps;
    // a request still high on the idle cycle simply starts a fresh walk.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= RF_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= RF_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                RF_CLEAR: begin
                    if (r_ptr == LAST) begin
                        r_state <= RF_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign o_clr_busy = (r_state == RF_CLEAR);
    assign o_clr_we   = (r_state == RF_CLEAR);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with two combinational read ports, one synchronous write port,
// a per-register busy scoreboard and a sequenced bulk clear.
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   N1/Q1/BUSY1         read port 1: id, data, scoreboard bit
//   N2/Q2/BUSY2         read port 2: id, data, scoreboard bit
//   ND/DI/REG_WE        write-back: id, data, enable (clears busy)
//   NI/ISSUE            issue: destination id, enable (sets busy)
//   CLR_REQ/CLR_BUSY    bulk-clear request / clear in progress
// Build option:
//   REGFILE_BYPASS_EN   forwards the write-back data and busy onto a read port
//                       in the same cycle when the ids match.
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] N1,
    output logic [WIDTH-1:0]  Q1,
    output logic              BUSY1,
    input  logic [ADDR_W-1:0] N2,
    output logic [WIDTH-1:0]  Q2,
    output logic              BUSY2,
    input  logic [ADDR_W-1:0] ND,
    input  logic [WIDTH-1:0]  DI,
    input  logic              REG_WE,
    input  logic [ADDR_W-1:0] NI,
    input  logic              ISSUE,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY
);

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_clrWe;
    logic [ADDR_W-1:0] w_clrAddr;
    logic              w_clrBusy;
    logic              w_we;
    logic              w_issue;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] id);
        return (ZERO_REG != 0) && (id == '0);
    endfunction

    regfile_sb_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clearSeq (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_clr_req  (CLR_REQ),
        .o_clr_we   (w_clrWe),
        .o_clr_addr (w_clrAddr),
        .o_clr_busy (w_clrBusy)
    );

    assign CLR_BUSY = w_clrBusy;

    // Writes and issues are dropped, not stalled, while a clear runs; the
    // hard-wired zero register swallows them as well.
    assign w_we    = REG_WE && !w_clrBusy && !isZeroReg(ND);
    assign w_issue = ISSUE  && !w_clrBusy && !isZeroReg(NI);

    // Issue is applied after write-back so that when both target the same
    // register the data lands but the register stays busy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else if (w_clrWe) begin
            r_regs[w_clrAddr] <= '0;
            r_busy[w_clrAddr] <= 1'b0;
        end else begin
            if (w_we) begin
                r_regs[ND] <= DI;
                r_busy[ND] <= 1'b0;
            end
            if (w_issue) begin
                r_busy[NI] <= 1'b1;
            end
        end
    end

    // Read ports; the zero register override is applied last so it also
    // masks any forwarded value.
    always_comb begin
        Q1    = r_regs[N1];
        BUSY1 = r_busy[N1];
        Q2    = r_regs[N2];
        BUSY2 = r_busy[N2];
`ifdef REGFILE_BYPASS_EN
        if (w_we && (ND == N1)) begin
            Q1    = DI;
            BUSY1 = w_issue && (NI == ND);
        end
        if (w_we && (ND == N2)) begin
            Q2    = DI;
            BUSY2 = w_issue && (NI == ND);
        end
`endif
        if (isZeroReg(N1)) begin
            Q1    = '0;
            BUSY1 = 1'b0;
        end
        if (isZeroReg(N2)) begin
            Q2    = '0;
            BUSY2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb (WIDTH=8, DEPTH=4). A behavioural model
// tracks register contents, busy bits and the remaining clear length; a second
// instance with ZERO_REG=1 shares the stimulus for the zero-register scenario.
// Honours REGFILE_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] N1, N2, ND, NI;
    logic [7:0] DI;
    logic       REG_WE, ISSUE, CLR_REQ;
    logic [7:0] Q1, Q2, Q1z, Q2z;
    logic       BUSY1, BUSY2, CLR_BUSY, BUSY1z, BUSY2z, CLR_BUSYz;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model state
    logic [7:0] mRegs [DEPTH];
    logic       mBusy [DEPTH];
    int         clrLeft;

    always #5 Clock = ~Clock;

    regfile_sb #(.WIDTH(8), .DEPTH(DEPTH), .ZERO_REG(0)) dut (
        .Clock(Clock), .Reset(Reset),
        .N1(N1), .Q1(Q1), .BUSY1(BUSY1),
        .N2(N2), .Q2(Q2), .BUSY2(BUSY2),
        .ND(ND), .DI(DI), .REG_WE(REG_WE),
        .NI(NI), .ISSUE(ISSUE),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY)
    );

    regfile_sb #(.WIDTH(8), .DEPTH(DEPTH), .ZERO_REG(1)) dutZero (
        .Clock(Clock), .Reset(Reset),
        .N1(N1), .Q1(Q1z), .BUSY1(BUSY1z),
        .N2(N2), .Q2(Q2z), .BUSY2(BUSY2z),
        .ND(ND), .DI(DI), .REG_WE(REG_WE),
        .NI(NI), .ISSUE(ISSUE),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSYz)
    );

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mRegs[i] = 8'h00;
            mBusy[i] = 1'b0;
        end
        clrLeft = 0;
    endfunction

    // One clock edge worth of architectural effect.
    function automatic void modelEdge();
        if (!Reset) return;
        if (clrLeft > 0) begin
            mRegs[DEPTH - clrLeft] = 8'h00;
            mBusy[DEPTH - clrLeft] = 1'b0;
            clrLeft--;
        end else begin
            if (REG_WE) begin
                mRegs[ND] = DI;
                mBusy[ND] = 1'b0;
            end
            if (ISSUE) mBusy[NI] = 1'b1;
            if (CLR_REQ) clrLeft = DEPTH;
        end
    endfunction

    function automatic logic [7:0] expQ(input logic [1:0] n);
`ifdef REGFILE_BYPASS_EN
        if (REG_WE && clrLeft == 0 && ND == n) return DI;
`endif
        return mRegs[n];
    endfunction

    function automatic logic expBusy(input logic [1:0] n);
`ifdef REGFILE_BYPASS_EN
        if (REG_WE && clrLeft == 0 && ND == n) return ISSUE && (NI == ND);
`endif
        return mBusy[n];
    endfunction

    task automatic tick();
        modelEdge();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyIdle();
        REG_WE = 0; ISSUE = 0; CLR_REQ = 0;
    endtask

    task automatic test_reset();
        Reset = 0; applyIdle();
        N1 = 2'd0; N2 = 2'd3; ND = 0; NI = 0; DI = 0;
        modelReset();
        #1;
        checkCount++; if (Q1 !== 8'h00) $display("[TB] FAIL rst_q1 got %h want 00", Q1); else passCount++;
        checkCount++; if (Q2 !== 8'h00) $display("[TB] FAIL rst_q2 got %h want 00", Q2); else passCount++;
        checkCount++; if (BUSY1 !== 1'b0) $display("[TB] FAIL rst_busy1 got %b want 0", BUSY1); else passCount++;
        checkCount++; if (BUSY2 !== 1'b0) $display("[TB] FAIL rst_busy2 got %b want 0", BUSY2); else passCount++;
        checkCount++; if (CLR_BUSY !== 1'b0) $display("[TB] FAIL rst_clrbusy got %b want 0", CLR_BUSY); else passCount++;
        tick(); tick();
        Reset = 1;
        tick();
    endtask

    task automatic test_write_read();
        REG_WE = 1; ND = 2'd2; DI = 8'hA5; N1 = 2'd2;
        #1;
        checkCount++; if (Q1 !== expQ(2'd2)) $display("[TB] FAIL wr_same_cycle got %h want %h", Q1, expQ(2'd2)); else passCount++;
        tick();
        applyIdle();
        #1;
        checkCount++; if (Q1 !== 8'hA5) $display("[TB] FAIL wr_next_cycle got %h want a5", Q1); else passCount++;
    endtask

    task automatic test_issue();
        ISSUE = 1; NI = 2'd3; N1 = 2'd3;
        tick();
        applyIdle();
        #1;
        checkCount++; if (BUSY1 !== 1'b1) $display("[TB] FAIL issue_busy got %b want 1", BUSY1); else passCount++;
        REG_WE = 1; ND = 2'd3; DI = 8'h3C;
        tick();
        applyIdle();
        #1;
        checkCount++; if (BUSY1 !== 1'b0) $display("[TB] FAIL wb_busy got %b want 0", BUSY1); else passCount++;
        checkCount++; if (Q1 !== 8'h3C) $display("[TB] FAIL wb_q got %h want 3c", Q1); else passCount++;
        REG_WE = 1; ISSUE = 1; ND = 2'd1; NI = 2'd1; DI = 8'h6E; N2 = 2'd1;
        tick();
        applyIdle();
        #1;
        checkCount++; if (BUSY2 !== 1'b1) $display("[TB] FAIL same_edge_busy got %b want 1", BUSY2); else passCount++;
        checkCount++; if (Q2 !== 8'h6E) $display("[TB] FAIL same_edge_q got %h want 6e", Q2); else passCount++;
    endtask

    task automatic test_clear();
        int highCycles = 0;
        logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int r = 0; r < DEPTH; r++) begin
            REG_WE = 1; ND = 2'(r); DI = fill[r];
            tick();
        end
        applyIdle();
        N1 = 2'd1; N2 = 2'd3;
        #1;
        checkCount++; if (Q2 !== 8'h44) $display("[TB] FAIL fill_r3 got %h want 44", Q2); else passCount++;
        CLR_REQ = 1;
        tick();
        CLR_REQ = 0;
        for (int k = 0; k < 8; k++) begin
            REG_WE = (k == 0); ND = 2'd1; DI = 8'h77;
            #1;
            checkCount++;
            if (CLR_BUSY !== (clrLeft > 0)) $display("[TB] FAIL clr_busy_k%0d got %b want %b", k, CLR_BUSY, clrLeft > 0);
            else passCount++;
            if (CLR_BUSY === 1'b1) highCycles++;
            tick();
        end
        applyIdle();
        checkCount++; if (highCycles != DEPTH) $display("[TB] FAIL clr_length got %0d want %0d", highCycles, DEPTH); else passCount++;
        for (int r = 0; r < DEPTH; r++) begin
            N1 = 2'(r);
            #1;
            checkCount++; if (Q1 !== 8'h00) $display("[TB] FAIL clr_zero_r%0d got %h want 00", r, Q1); else passCount++;
        end
    endtask

    task automatic test_clear_reset();
        REG_WE = 1; ND = 2'd3; DI = 8'h99; ISSUE = 1; NI = 2'd0;
        tick();
        applyIdle();
        CLR_REQ = 1;
        tick();
        CLR_REQ = 0;
        tick();
        #2;
        Reset = 0;
        modelReset();
        N1 = 2'd3; N2 = 2'd0;
        #1;
        checkCount++; if (CLR_BUSY !== 1'b0) $display("[TB] FAIL midclr_rst_busy got %b want 0", CLR_BUSY); else passCount++;
        checkCount++; if (Q1 !== 8'h00) $display("[TB] FAIL midclr_rst_q3 got %h want 00", Q1); else passCount++;
        checkCount++; if (BUSY2 !== 1'b0) $display("[TB] FAIL midclr_rst_busy0 got %b want 0", BUSY2); else passCount++;
        tick();
        Reset = 1;
        tick();
        #1;
        checkCount++; if (CLR_BUSY !== 1'b0) $display("[TB] FAIL postrst_clrbusy got %b want 0", CLR_BUSY); else passCount++;
    endtask

    task automatic test_clr_hold();
        CLR_REQ = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checkCount++;
            if (CLR_BUSY !== (clrLeft > 0)) $display("[TB] FAIL hold_busy_k%0d got %b want %b", k, CLR_BUSY, clrLeft > 0);
            else passCount++;
            tick();
        end
        CLR_REQ = 0;
        repeat (DEPTH + 1) tick();
        #1;
        checkCount++; if (CLR_BUSY !== 1'b0) $display("[TB] FAIL hold_drain got %b want 0", CLR_BUSY); else passCount++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            N1 = 2'($urandom); N2 = 2'($urandom);
            ND = 2'($urandom); NI = 2'($urandom);
            DI = 8'($urandom);
            REG_WE  = 1'($urandom);
            ISSUE   = 1'($urandom);
            CLR_REQ = ($urandom_range(0, 19) == 0);
            #1;
            checkCount++; if (Q1 !== expQ(N1)) $display("[TB] FAIL rnd_q1 c%0d got %h want %h", c, Q1, expQ(N1)); else passCount++;
            checkCount++; if (Q2 !== expQ(N2)) $display("[TB] FAIL rnd_q2 c%0d got %h want %h", c, Q2, expQ(N2)); else passCount++;
            checkCount++; if (BUSY1 !== expBusy(N1)) $display("[TB] FAIL rnd_busy1 c%0d got %b want %b", c, BUSY1, expBusy(N1)); else passCount++;
            checkCount++; if (BUSY2 !== expBusy(N2)) $display("[TB] FAIL rnd_busy2 c%0d got %b want %b", c, BUSY2, expBusy(N2)); else passCount++;
            checkCount++; if (CLR_BUSY !== (clrLeft > 0)) $display("[TB] FAIL rnd_clrbusy c%0d got %b want %b", c, CLR_BUSY, clrLeft > 0); else passCount++;
            tick();
        end
        applyIdle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_zero_reg();
        REG_WE = 1; ND = 2'd0; DI = 8'hFF; ISSUE = 1; NI = 2'd0;
        N1 = 2'd0; N2 = 2'd2;
        tick();
        REG_WE = 1; ND = 2'd2; DI = 8'h5C; ISSUE = 0;
        tick();
        applyIdle();
        #1;
        checkCount++; if (Q1z !== 8'h00) $display("[TB] FAIL zero_q got %h want 00", Q1z); else passCount++;
        checkCount++; if (BUSY1z !== 1'b0) $display("[TB] FAIL zero_busy got %b want 0", BUSY1z); else passCount++;
        checkCount++; if (Q2z !== 8'h5C) $display("[TB] FAIL zero_other_q got %h want 5c", Q2z); else passCount++;
        checkCount++; if (Q1 !== 8'hFF) $display("[TB] FAIL nonzero_r0_q got %h want ff", Q1); else passCount++;
        checkCount++; if (BUSY1 !== 1'b1) $display("[TB] FAIL nonzero_r0_busy got %b want 1", BUSY1); else passCount++;
    endtask

    task automatic test_bypass();
        logic [7:0] want;
        REG_WE = 1; ND = 2'd1; DI = 8'h12;
        tick();
        REG_WE = 1; ND = 2'd1; DI = 8'h5A; N1 = 2'd1;
`ifdef REGFILE_BYPASS_EN
        want = 8'h5A;
`else
        want = 8'h12;
`endif
        #1;
        checkCount++; if (Q1 !== want) $display("[TB] FAIL bypass_same_cycle got %h want %h", Q1, want); else passCount++;
        tick();
        applyIdle();
        #1;
        checkCount++; if (Q1 !== 8'h5A) $display("[TB] FAIL bypass_next_cycle got %h want 5a", Q1); else passCount++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_issue();
        test_clear();
        test_clear_reset();
        test_clr_hold();
        test_random();
        test_zero_reg();
        test_bypass();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
